dyt_operand_fetch: RTL

DYT_OPERAND_FETCH -- requirements
Module: dyt_operand_fetch

---
 rtl/dyt_operand_fetch_pkg.sv | 21 ++
 rtl/dyt_operand_fetch_if.sv | 48 ++++
 rtl/dyt_operand_fetch_scoreboard.sv | 38 +++
 rtl/dyt_operand_fetch.sv | 88 ++++++++
 4 files changed

// File: rtl/dyt_operand_fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// common_types : shared word/select types and the scoreboard hazard helper
// Revision     : 1.0
//------------------------------------------------------------------------------
package common_types;
   localparam int DATA_WIDTH = 32;
   localparam int NREGS      = 32;
   localparam int SEL_WIDTH  = $clog2(NREGS);

   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [SEL_WIDTH-1:0]  regbits_t;
   typedef logic [NREGS-1:0]      pending_t;

   // A writeback landing this cycle resolves the hazard through the bypass.
   function automatic logic hazard(input pending_t pend, input regbits_t r,
                                   input logic wb_v, input regbits_t wb_r);
      return pend[r] && (r != '0) && !(wb_v && (wb_r == r));
   endfunction
endpackage
`default_nettype wire

// File: rtl/dyt_operand_fetch_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// dyt_operand_fetch_if : decode, register-file, writeback and execute signals
// Revision             : 1.0
//------------------------------------------------------------------------------
interface dyt_operand_fetch_if;
   import common_types::*;

   logic     id_valid;
   logic     id_ready;
   regbits_t id_rs1;
   regbits_t id_rs2;
   regbits_t id_rd;
   logic     id_rd_wen;
   regbits_t rf_r_sel_0;
   regbits_t rf_r_sel_1;
   word_t    rf_r_data_0;
   word_t    rf_r_data_1;
   logic     wb_valid;
   regbits_t wb_rd;
   word_t    wb_data;
   logic     ex_valid;
   logic     ex_ready;
   word_t    ex_op_a;
   word_t    ex_op_b;
   regbits_t ex_rd;
   logic     ex_rd_wen;
   logic     flush;

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_rd_wen,
      input  rf_r_data_0, rf_r_data_1,
      input  wb_valid, wb_rd, wb_data,
      input  ex_ready, flush,
      output id_ready, rf_r_sel_0, rf_r_sel_1,
      output ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wen
   );

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_rd_wen,
      output rf_r_data_0, rf_r_data_1,
      output wb_valid, wb_rd, wb_data,
      output ex_ready, flush,
      input  id_ready, rf_r_sel_0, rf_r_sel_1,
      input  ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wen
   );
endinterface
`default_nettype wire

// File: rtl/dyt_operand_fetch_scoreboard.sv
`default_nettype none
//------------------------------------------------------------------------------
// dyt_scoreboard : one pending bit per register; set beats clear, flush beats all
// Revision       : 1.0
//------------------------------------------------------------------------------
module dyt_scoreboard
   import common_types::*;
#(
   parameter int NREGS_P = common_types::NREGS
) (
   input  wire                clk,
   input  wire                n_rst,
   input  wire                set_en,
   input  regbits_t           set_idx,
   input  wire                clr_en,
   input  regbits_t           clr_idx,
   input  wire                flush,
   output logic [NREGS_P-1:0] pending
);
   logic [NREGS_P-1:0] r_pending;
   logic [NREGS_P-1:0] w_next;

   always_comb begin
      w_next = r_pending;
      if (clr_en) w_next[clr_idx] = 1'b0;
      if (set_en) w_next[set_idx] = 1'b1;
      w_next[0] = 1'b0;
      if (flush) w_next = '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_pending <= '0;
      else        r_pending <= w_next;
   end

   assign pending = r_pending;
endmodule
`default_nettype wire

// File: rtl/dyt_operand_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// dyt_operand_fetch : operand read with writeback bypass, scoreboard stall and
//                     a single registered issue stage toward execute
// Revision          : 1.0
//------------------------------------------------------------------------------
module dyt_operand_fetch #(
   parameter int WIDTH = common_types::DATA_WIDTH,
   parameter int NREGS = common_types::NREGS
) (
   input wire                   clk,
   input wire                   n_rst,
   dyt_operand_fetch_if.slave   bus
);
   import common_types::*;

   logic [NREGS-1:0] w_pending;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic             w_stall;
   logic             w_issue;
   logic             w_id_ready;

   logic             r_ex_valid;
   logic [WIDTH-1:0] r_ex_op_a;
   logic [WIDTH-1:0] r_ex_op_b;
   regbits_t         r_ex_rd;
   logic             r_ex_rd_wen;

   assign bus.rf_r_sel_0 = bus.id_rs1;
   assign bus.rf_r_sel_1 = bus.id_rs2;

   always_comb begin
      w_op_a = bus.rf_r_data_0;
      if (bus.id_rs1 == '0)                              w_op_a = '0;
      else if (bus.wb_valid && (bus.wb_rd == bus.id_rs1)) w_op_a = bus.wb_data;
      w_op_b = bus.rf_r_data_1;
      if (bus.id_rs2 == '0)                              w_op_b = '0;
      else if (bus.wb_valid && (bus.wb_rd == bus.id_rs2)) w_op_b = bus.wb_data;
   end

   assign w_stall = hazard(w_pending, bus.id_rs1, bus.wb_valid, bus.wb_rd)
                 || hazard(w_pending, bus.id_rs2, bus.wb_valid, bus.wb_rd)
                 || (bus.id_rd_wen && hazard(w_pending, bus.id_rd, bus.wb_valid, bus.wb_rd));

   assign w_id_ready = !w_stall && (!r_ex_valid || bus.ex_ready) && !bus.flush;
   assign w_issue    = bus.id_valid && w_id_ready;
   assign bus.id_ready = w_id_ready;

   dyt_scoreboard #(.NREGS_P(NREGS)) u_sb (
      .clk     (clk),
      .n_rst   (n_rst),
      .set_en  (w_issue && bus.id_rd_wen),
      .set_idx (bus.id_rd),
      .clr_en  (bus.wb_valid),
      .clr_idx (bus.wb_rd),
      .flush   (bus.flush),
      .pending (w_pending)
   );

   // Payload only moves on issue, so it holds while execute back-pressures.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_ex_valid  <= 1'b0;
         r_ex_op_a   <= '0;
         r_ex_op_b   <= '0;
         r_ex_rd     <= '0;
         r_ex_rd_wen <= 1'b0;
      end else if (bus.flush) begin
         r_ex_valid  <= 1'b0;
      end else if (w_issue) begin
         r_ex_valid  <= 1'b1;
         r_ex_op_a   <= w_op_a;
         r_ex_op_b   <= w_op_b;
         r_ex_rd     <= bus.id_rd;
         r_ex_rd_wen <= bus.id_rd_wen;
      end else if (bus.ex_ready) begin
         r_ex_valid  <= 1'b0;
      end
   end

   assign bus.ex_valid  = r_ex_valid;
   assign bus.ex_op_a   = r_ex_op_a;
   assign bus.ex_op_b   = r_ex_op_b;
   assign bus.ex_rd     = r_ex_rd;
   assign bus.ex_rd_wen = r_ex_rd_wen;
endmodule
`default_nettype wire
